// File: rtl/i2c_sram_master_pkg.sv
// Shared definitions for the I2C SRAM master.
// Contents: FSM state encoding, R/W and ACK bus levels, quarter-phase codes,
// and a helper that picks the next byte to transmit from the byte index.
package i2c_sram_master_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_START   = 4'd1,
        ST_TX_BYTE = 4'd2,
        ST_GET_ACK = 4'd3,
        ST_RESTART = 4'd4,
        ST_RX_BYTE = 4'd5,
        ST_PUT_ACK = 4'd6,
        ST_STOP    = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    localparam logic I2C_WR   = 1'b0;
    localparam logic I2C_RD   = 1'b1;
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Quarter-phase codes within one bit time (scl low in Q0/Q1, high in Q2/Q3).
    localparam logic [1:0] QUARTER_SAMPLE = 2'd2;
    localparam logic [1:0] QUARTER_LAST   = 2'd3;

    // Byte index 0: address+W, 1: memory address, 2: wdata high (write) or
    // address+R after the repeated START (read), 3: wdata low.
    function automatic logic [7:0] tx_byte_sel(input logic [1:0]  idx,
                                               input logic        rw,
                                               input logic [6:0]  dev,
                                               input logic [7:0]  mem,
                                               input logic [15:0] wd);
        logic [7:0] b;
        case (idx)
            2'd0:    b = {dev, I2C_WR};
            2'd1:    b = mem;
            2'd2:    b = (rw == I2C_RD) ? {dev, I2C_RD} : wd[15:8];
            default: b = wd[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/i2c_sram_master_bit_timer.sv
// Quarter-phase timer for the I2C master.
// Ports:
//   clk, reset   system clock, asynchronous active-low reset
//   clear        hold the divider and quarter index at zero (master idle)
//   qtick        one-clk pulse on the last clk of every quarter
//   quarter      current quarter index 0..3 within the bit time
module i2c_sram_master_bit_timer
    import i2c_sram_master_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    output logic       qtick,
    output logic [1:0] quarter
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign qtick = !clear && (cnt == LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            quarter <= 2'd0;
        end else if (clear) begin
            cnt     <= '0;
            quarter <= 2'd0;
        end else if (cnt == LAST) begin
            cnt     <= '0;
            quarter <= quarter + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_sram_master.sv
// I2C master for a 16-bit SRAM slave: one host request becomes a full bus
// transaction (write: address + one word; read: address, Sr, one word).
// Ports:
//   clk, reset            system clock, asynchronous active-low reset
//   start, rw, dev_addr,  request pulse and its parameters, captured in IDLE
//   mem_addr, wdata
//   rdata                 last successfully read word
//   busy, done, nack      status; nack is meaningful while done=1
//   scl                   push-pull bus clock, idles high
//   sda                   open-drain bus data (0 or Z)
//   dbg_state             current FSM state
//
// Handshake: start is honoured only in IDLE; busy is high from the cycle after
// acceptance until the done cycle, and done is a single-cycle pulse.
module i2c_sram_master
    import i2c_sram_master_pkg::*;
#(
    parameter int CLK_DIV = 25
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        rw,
    input  logic [6:0]  dev_addr,
    input  logic [7:0]  mem_addr,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        nack,
    output logic        scl,
    inout  wire         sda,
    output logic [3:0]  dbg_state
);

    state_t      state, state_n;
    logic [1:0]  byte_idx, idx_n;
    logic [2:0]  bit_cnt;
    logic [7:0]  tx_sh;
    logic [15:0] rx_sh;
    logic        rw_q, ack_bit, nack_q;
    logic [6:0]  dev_q;
    logic [7:0]  mem_q;
    logic [15:0] wdata_q;
    logic        sda_s1, sda_s2;
    logic        scl_dec, sda_dec, sda_pre, sda_low;
    logic        qtick, bit_end, sample;
    logic [1:0]  quarter;

    i2c_sram_master_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   ((state == ST_IDLE) || (state == ST_DONE)),
        .qtick   (qtick),
        .quarter (quarter)
    );

    assign bit_end   = qtick && (quarter == QUARTER_LAST);
    assign sample    = qtick && (quarter == QUARTER_SAMPLE);
    assign busy      = (state != ST_IDLE) && (state != ST_DONE);
    assign done      = (state == ST_DONE);
    assign nack      = nack_q;
    assign dbg_state = state;
    assign sda       = sda_low ? 1'b0 : 1'bz;

    always_comb begin
        state_n = state;
        idx_n   = byte_idx;
        scl_dec = 1'b1;
        sda_dec = 1'b0;
        case (state)
            ST_IDLE: if (start) begin
                state_n = ST_START;
                idx_n   = 2'd0;
            end
            ST_START: begin
                sda_dec = quarter[1];        // SDA falls mid-bit while SCL stays high
                if (bit_end) state_n = ST_TX_BYTE;
            end
            ST_TX_BYTE: begin
                scl_dec = quarter[1];
                sda_dec = !tx_sh[7];
                if (bit_end && bit_cnt == 3'd7) state_n = ST_GET_ACK;
            end
            ST_GET_ACK: begin
                scl_dec = quarter[1];
                if (bit_end) begin
                    if (ack_bit == I2C_NACK) begin
                        state_n = ST_STOP;
                    end else if (rw_q == I2C_WR && byte_idx == 2'd3) begin
                        state_n = ST_STOP;
                    end else if (rw_q == I2C_RD && byte_idx == 2'd1) begin
                        state_n = ST_RESTART;
                        idx_n   = 2'd2;
                    end else if (rw_q == I2C_RD && byte_idx == 2'd2) begin
                        state_n = ST_RX_BYTE;
                    end else begin
                        state_n = ST_TX_BYTE;
                        idx_n   = byte_idx + 2'd1;
                    end
                end
            end
            ST_RESTART: begin
                scl_dec = quarter[1];
                sda_dec = (quarter == QUARTER_LAST);
                if (bit_end) state_n = ST_TX_BYTE;
            end
            ST_RX_BYTE: begin
                scl_dec = quarter[1];
                if (bit_end && bit_cnt == 3'd7) state_n = ST_PUT_ACK;
            end
            ST_PUT_ACK: begin
                scl_dec = quarter[1];
                // First read byte gets ACK, the last one NACK.
                sda_dec = (byte_idx == 2'd2) ? (I2C_ACK == 1'b0) : 1'b0;
                if (bit_end) begin
                    if (byte_idx == 2'd2) begin
                        state_n = ST_RX_BYTE;
                        idx_n   = 2'd3;
                    end else begin
                        state_n = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                scl_dec = quarter[1];
                sda_dec = (quarter != QUARTER_LAST);
                if (bit_end) state_n = ST_DONE;
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    // SCL is registered once and SDA twice, so every SDA change lands one clk
    // after the SCL edge that precedes it; reset releases both at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl     <= 1'b1;
            sda_pre <= 1'b0;
            sda_low <= 1'b0;
            sda_s1  <= 1'b1;
            sda_s2  <= 1'b1;
        end else begin
            scl     <= scl_dec;
            sda_pre <= sda_dec;
            sda_low <= sda_pre;
            sda_s1  <= sda;
            sda_s2  <= sda_s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx <= 2'd0;
            bit_cnt  <= 3'd0;
            tx_sh    <= 8'd0;
            rx_sh    <= 16'd0;
            rw_q     <= 1'b0;
            dev_q    <= 7'd0;
            mem_q    <= 8'd0;
            wdata_q  <= 16'd0;
            ack_bit  <= 1'b0;
            nack_q   <= 1'b0;
            rdata    <= 16'd0;
        end else begin
            byte_idx <= idx_n;
            if (state == ST_IDLE && start) begin
                rw_q    <= rw;
                dev_q   <= dev_addr;
                mem_q   <= mem_addr;
                wdata_q <= wdata;
                nack_q  <= 1'b0;
                bit_cnt <= 3'd0;
            end
            if (state_n == ST_TX_BYTE && state != ST_TX_BYTE)
                tx_sh <= tx_byte_sel(idx_n, rw_q, dev_q, mem_q, wdata_q);
            else if (state == ST_TX_BYTE && bit_end)
                tx_sh <= {tx_sh[6:0], 1'b0};
            // 3-bit counter wraps to 0 at the end of each byte.
            if ((state == ST_TX_BYTE || state == ST_RX_BYTE) && bit_end)
                bit_cnt <= bit_cnt + 3'd1;
            if (state == ST_GET_ACK && sample)
                ack_bit <= sda_s2;
            if (state == ST_GET_ACK && bit_end && ack_bit == I2C_NACK)
                nack_q <= 1'b1;
            if (state == ST_RX_BYTE && sample)
                rx_sh <= {rx_sh[14:0], sda_s2};
            if (state == ST_DONE && rw_q == I2C_RD && !nack_q)
                rdata <= rx_sh;
        end
    end

endmodule

// File: tb/tb_i2c_sram_master.sv
// Bench for i2c_sram_master: master + behavioural SRAM slave (address 7'h50)
// + pull-up + bus monitor that turns the bus into S/P/byte+ack tokens.
module tb_i2c_sram_master;

    localparam logic [9:0] TOK_S = 10'h200;
    localparam logic [9:0] TOK_P = 10'h201;
    localparam logic [6:0] MY_ADDR = 7'h50;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, rw;
    logic [6:0]  dev_addr;
    logic [7:0]  mem_addr;
    logic [15:0] wdata, rdata;
    logic        busy, done, nack, scl;
    logic [3:0]  dbg_state;
    wire         sda;
    logic        slave_low = 1'b0;

    pullup (sda);
    assign sda = slave_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    i2c_sram_master #(.CLK_DIV(4)) dut (
        .clk(clk), .reset(reset), .start(start), .rw(rw), .dev_addr(dev_addr),
        .mem_addr(mem_addr), .wdata(wdata), .rdata(rdata), .busy(busy),
        .done(done), .nack(nack), .scl(scl), .sda(sda), .dbg_state(dbg_state)
    );

    int checks = 0;
    int failures = 0;
    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] tok(input logic [7:0] b, input logic a);
        return {1'b0, b, a};
    endfunction

    // ---------------- SRAM slave model ----------------
    localparam int SL_IDLE = 0, SL_RX = 1, SL_ACKD = 2, SL_ACKH = 3,
                   SL_TX = 4, SL_MWAIT = 5, SL_MACK = 6, SL_MNEXT = 7;
    logic [15:0] sram [256];
    logic        s_scl_r = 1'b1, s_sda_r = 1'b1;
    int          s_state = SL_IDLE, s_bitn = 0, s_idx = 0;
    logic [7:0]  s_sh = 8'd0, s_tx = 8'd0, s_hi = 8'd0, s_ptr = 8'd0;
    logic        s_rw = 1'b0, s_ack = 1'b0;

    initial for (int i = 0; i < 256; i++) sram[i] = 16'h0000;

    always @(negedge clk) begin
        s_scl_r <= scl;
        s_sda_r <= sda;
        if (scl === 1'b1 && s_scl_r && s_sda_r && sda === 1'b0) begin
            s_state <= SL_RX; s_bitn <= 0; s_idx <= 0; slave_low <= 1'b0;
        end else if (scl === 1'b1 && s_scl_r && !s_sda_r && sda === 1'b1) begin
            s_state <= SL_IDLE; slave_low <= 1'b0;
        end else if (scl === 1'b1 && !s_scl_r) begin
            case (s_state)
                SL_RX: begin
                    s_sh   <= {s_sh[6:0], sda};
                    s_bitn <= s_bitn + 1;
                    if (s_bitn == 7) begin
                        s_state <= SL_ACKD;
                        s_idx   <= s_idx + 1;
                        s_ack   <= 1'b1;
                        case (s_idx)
                            0: begin s_ack <= (s_sh[6:0] == MY_ADDR); s_rw <= sda; end
                            1: s_ptr <= {s_sh[6:0], sda};
                            2: s_hi  <= {s_sh[6:0], sda};
                            3: sram[s_ptr] <= {s_hi, s_sh[6:0], sda};
                            default: ;
                        endcase
                    end
                end
                SL_TX: begin
                    s_bitn <= s_bitn + 1;
                    if (s_bitn == 7) s_state <= SL_MWAIT;
                end
                SL_MACK: begin
                    if (sda === 1'b0) begin s_tx <= sram[s_ptr][7:0]; s_state <= SL_MNEXT; end
                    else s_state <= SL_IDLE;
                end
                default: ;
            endcase
        end else if (scl === 1'b0 && s_scl_r) begin
            case (s_state)
                SL_ACKD: begin slave_low <= s_ack; s_state <= SL_ACKH; end
                SL_ACKH: begin
                    slave_low <= 1'b0;
                    if (!s_ack) s_state <= SL_IDLE;
                    else if (s_rw && s_idx == 1) begin
                        s_tx <= sram[s_ptr][15:8]; slave_low <= !sram[s_ptr][15];
                        s_bitn <= 0; s_state <= SL_TX;
                    end else begin
                        s_bitn <= 0; s_state <= SL_RX;
                    end
                end
                SL_TX:    slave_low <= !s_tx[7 - s_bitn];
                SL_MWAIT: begin slave_low <= 1'b0; s_state <= SL_MACK; end
                SL_MNEXT: begin slave_low <= !s_tx[7]; s_bitn <= 0; s_state <= SL_TX; end
                default: ;
            endcase
        end
    end

    // ---------------- bus monitor ----------------
    // Any SDA edge while SCL is high shows up as an S or P token, so a stray
    // one breaks the expected token sequence.
    logic       m_scl_r = 1'b1, m_sda_r = 1'b1;
    int         m_cnt = 0;
    logic [7:0] m_sh = 8'd0;

    always @(negedge clk) begin
        m_scl_r <= scl;
        m_sda_r <= sda;
        if (scl === 1'b1 && m_scl_r && m_sda_r && sda === 1'b0) begin
            got_q.push_back(TOK_S); m_cnt <= 0;
        end else if (scl === 1'b1 && m_scl_r && !m_sda_r && sda === 1'b1) begin
            got_q.push_back(TOK_P); m_cnt <= 0;
        end else if (scl === 1'b1 && !m_scl_r) begin
            if (m_cnt == 8) begin
                got_q.push_back({1'b0, m_sh, sda}); m_cnt <= 0;
            end else begin
                m_sh <= {m_sh[6:0], sda}; m_cnt <= m_cnt + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] m, input logic [15:0] w);
        rw = r; dev_addr = d; mem_addr = m; wdata = w; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_rise", busy, 1);
    endtask

    task automatic wait_done(input string tag, output int cyc);
        logic seen;
        seen = 1'b0;
        cyc = 0;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            seen = done;
        end
        check({tag, "_done_seen"}, seen, 1);
    endtask

    task automatic check_tokens(input string tag);
        check({tag, "_tok_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("%s_tok%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic after_done(input string tag);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_low"}, busy, 0);
    endtask

    // ---------------- directed tests ----------------
    int cyc;

    initial begin
        reset = 1'b0; start = 1'b0; rw = 1'b0;
        dev_addr = 7'd0; mem_addr = 8'd0; wdata = 16'd0;
        repeat (5) @(negedge clk);
        check("rst_scl", scl, 1);
        check("rst_sda", sda, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_nack", nack, 0);
        check("rst_rdata", rdata, 16'h0000);
        check("rst_state", dbg_state, 4'd0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        got_q.delete();

        // 1: write BEEF to 0x12
        exp_q.push_back(TOK_S);           exp_q.push_back(tok(8'hA0, 1'b0));
        exp_q.push_back(tok(8'h12, 1'b0)); exp_q.push_back(tok(8'hBE, 1'b0));
        exp_q.push_back(tok(8'hEF, 1'b0)); exp_q.push_back(TOK_P);
        issue(1'b0, 7'h50, 8'h12, 16'hBEEF);
        wait_done("wr1", cyc);
        check("wr1_cycles", cyc, 608);
        check("wr1_nack", nack, 0);
        check_tokens("wr1");
        after_done("wr1");
        check("wr1_sram", sram[8'h12], 16'hBEEF);

        // 2: read back 0x12
        exp_q.push_back(TOK_S);           exp_q.push_back(tok(8'hA0, 1'b0));
        exp_q.push_back(tok(8'h12, 1'b0)); exp_q.push_back(TOK_S);
        exp_q.push_back(tok(8'hA1, 1'b0)); exp_q.push_back(tok(8'hBE, 1'b0));
        exp_q.push_back(tok(8'hEF, 1'b1)); exp_q.push_back(TOK_P);
        issue(1'b1, 7'h50, 8'h12, 16'h0000);
        wait_done("rd1", cyc);
        check("rd1_cycles", cyc, 768);
        check("rd1_nack", nack, 0);
        check_tokens("rd1");
        after_done("rd1");
        check("rd1_rdata", rdata, 16'hBEEF);

        // 3: wrong device address -> NACK on first byte
        exp_q.push_back(TOK_S); exp_q.push_back(tok(8'hA2, 1'b1)); exp_q.push_back(TOK_P);
        issue(1'b0, 7'h51, 8'h12, 16'h5555);
        wait_done("nak", cyc);
        check("nak_cycles", cyc, 176);
        check("nak_nack", nack, 1);
        check_tokens("nak");
        after_done("nak");
        check("nak_rdata_kept", rdata, 16'hBEEF);
        check("nak_sram_kept", sram[8'h12], 16'hBEEF);

        // 4: start while busy and during the done cycle is ignored
        exp_q.push_back(TOK_S);           exp_q.push_back(tok(8'hA0, 1'b0));
        exp_q.push_back(tok(8'h20, 1'b0)); exp_q.push_back(tok(8'hA5, 1'b0));
        exp_q.push_back(tok(8'h5A, 1'b0)); exp_q.push_back(TOK_P);
        issue(1'b0, 7'h50, 8'h20, 16'hA55A);
        repeat (100) @(negedge clk);
        rw = 1'b1; dev_addr = 7'h51; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign", cyc);
        check("ign_cycles", cyc + 101, 608);
        check("ign_nack", nack, 0);
        check_tokens("ign");
        rw = 1'b0; dev_addr = 7'h50; mem_addr = 8'h21; wdata = 16'h0F0F; start = 1'b1;
        @(negedge clk);
        check("done_start_ignored", busy, 0);
        check("done_start_state", dbg_state, 4'd0);
        @(negedge clk);
        start = 1'b0;
        check("idle_start_accepted", busy, 1);
        wait_done("acc", cyc);
        check("acc_cycles", cyc, 608);
        after_done("acc");
        check("ign_sram20", sram[8'h20], 16'hA55A);
        check("acc_sram21", sram[8'h21], 16'h0F0F);
        got_q.delete();

        // 5: async reset in the middle of wdata[15:8]
        issue(1'b0, 7'h50, 8'h30, 16'hC3C3);
        repeat (310) @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_scl", scl, 1);
        check("mid_rst_sda", sda, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_state", dbg_state, 4'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_sram30", sram[8'h30], 16'h0000);
        got_q.delete();
        exp_q.push_back(TOK_S);           exp_q.push_back(tok(8'hA0, 1'b0));
        exp_q.push_back(tok(8'h07, 1'b0)); exp_q.push_back(tok(8'h12, 1'b0));
        exp_q.push_back(tok(8'h34, 1'b0)); exp_q.push_back(TOK_P);
        issue(1'b0, 7'h50, 8'h07, 16'h1234);
        wait_done("wr2", cyc);
        check("wr2_cycles", cyc, 608);
        check("wr2_nack", nack, 0);
        check_tokens("wr2");
        after_done("wr2");
        check("wr2_sram", sram[8'h07], 16'h1234);
        issue(1'b1, 7'h50, 8'h07, 16'h0000);
        wait_done("rd2", cyc);
        check("rd2_cycles", cyc, 768);
        check("rd2_nack", nack, 0);
        after_done("rd2");
        check("rd2_rdata", rdata, 16'h1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
